// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a 3x4 matrix keypad scanner's column drive with row responses for commanded key presses.
// Define KEYEMU_BOUNCE_EN to prepend a 4-tick contact-bounce pattern to every valid press.
module keypad_emulator #(
  parameter int TICK_DIV  = 12500,
  parameter int GAP_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int PW = $clog2(TICK_DIV + 1);
`ifdef KEYEMU_BOUNCE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, HOLD = 2'd2, GAP = 2'd3} state_t;
  localparam state_t FIRST = BOUNCE;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2, GAP = 2'd3} state_t;
  localparam state_t FIRST = HOLD;
`endif
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d, hold_q, hold_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic done_q, done_d, err_q, err_d, pressed, tick, bad;
  assign tick = presc_q == PW'(TICK_DIV - 1);
  assign bad = cmd_key > 4'd11;
  assign cmd_ready = state_q == IDLE;
  assign busy = ~cmd_ready;
  assign done = done_q;
  assign err = err_q;
  assign key_row = (pressed && key_col[col_q]) ? 4'(1) << row_q : 4'b0;
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d = tick ? cnt_q + 8'd1 : cnt_q;
    hold_d = hold_q;
    row_d = row_q;
    col_d = col_q;
    done_d = 1'b0;
    err_d = 1'b0;
    pressed = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d = '0;
        if (cmd_valid) begin
          err_d = bad;
          state_d = bad ? IDLE : FIRST;
          hold_d = cmd_hold == 8'd0 ? 8'd1 : cmd_hold;
          row_d = cmd_key inside {4'd1, 4'd2, 4'd3} ? 2'd0 :
                  cmd_key inside {4'd4, 4'd5, 4'd6} ? 2'd1 :
                  cmd_key inside {4'd7, 4'd8, 4'd9} ? 2'd2 : 2'd3;
          col_d = cmd_key inside {4'd1, 4'd4, 4'd7, 4'd10} ? 2'd0 :
                  cmd_key inside {4'd2, 4'd5, 4'd8, 4'd0} ? 2'd1 : 2'd2;
        end
      end
`ifdef KEYEMU_BOUNCE_EN
      BOUNCE: begin
        pressed = ~cnt_q[0];
        if (tick && cnt_q == 8'd3) begin
          state_d = HOLD;
          cnt_d = '0;
        end
      end
`endif
      HOLD: begin
        pressed = 1'b1;
        if (tick && cnt_q == hold_q - 8'd1) begin
          state_d = GAP;
          cnt_d = '0;
        end
      end
      GAP: begin
        if (tick && cnt_q == 8'(GAP_TICKS - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q <= '0;
      hold_q <= 8'd1;
      row_q <= '0;
      col_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      row_q <= row_d;
      col_q <= col_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized scoreboard bench for keypad_emulator against a timeline model of each press.
module tb_keypad_emulator;
  localparam int TD = 4;
  localparam int GT = 2;
`ifdef KEYEMU_BOUNCE_EN
  localparam int BT = 4;
`else
  localparam int BT = 0;
`endif
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic cmd_ready, busy, done, err;
  logic [2:0] key_col = 3'b000;
  logic [3:0] key_row;
  logic [3:0] cmd_key = 0;
  logic [7:0] cmd_hold = 0;
  int checks = 0, errors = 0, cyc = 0;
  bit rand_col = 0;
  typedef struct {bit bad; int acc; int key; int hold;} exp_t;
  exp_t q[$];
  int pad [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
  int m_row, m_o, m_h, m_due;
  bit m_rdy, m_done, m_err;

  keypad_emulator #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    if (rand_col) key_col = 3'($urandom);
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", n, $time, a, e);
    end
  endtask

  function automatic int row_of(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pad[r][c] == k) return r;
    return 0;
  endfunction

  function automatic int col_of(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pad[r][c] == k) return c;
    return 0;
  endfunction

  // o counts cycles since acceptance, starting at 0 in the first cycle after the accepting edge
  function automatic bit pressed_at(input int o, input int h);
    if (o < BT * TD) return ((o / TD) % 2) == 0;
    return (o - BT * TD) < h * TD;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      m_row = 0;
      m_rdy = 1;
      m_done = 0;
      m_err = 0;
      if (q.size() > 0) begin
        m_o = cyc - q[0].acc;
        m_h = q[0].hold == 0 ? 1 : q[0].hold;
        m_due = q[0].bad ? 0 : (BT + m_h + GT) * TD;
        if (!q[0].bad && pressed_at(m_o, m_h) && key_col[col_of(q[0].key)]) m_row = 1 << row_of(q[0].key);
        m_rdy = m_o >= m_due;
        m_done = !q[0].bad && m_o == m_due;
        m_err = q[0].bad && m_o == 0;
        if (m_o >= m_due) void'(q.pop_front());
      end
      chk("key_row", int'(key_row), m_row);
      chk("cmd_ready", int'(cmd_ready), int'(m_rdy));
      chk("busy", int'(busy), int'(!m_rdy));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
    end
  end

  task automatic setcol(input logic [2:0] c);
    @(posedge clk);
    #2 key_col = c;
  endtask

  task automatic issue(input logic [3:0] k, input logic [7:0] h);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 expected 1");
      return;
    end
    cmd_valid = 1;
    cmd_key = k;
    cmd_hold = h;
    @(posedge clk);
    #1;
    e.bad = k > 4'd11;
    e.acc = cyc;
    e.key = int'(k);
    e.hold = int'(h);
    q.push_back(e);
    cmd_valid = 0;
    cmd_key = 4'($urandom);
    cmd_hold = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_key_row"}, int'(key_row), 0);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #1;
    reset_outputs("rst0");
    repeat (3) @(negedge clk);
    #2 rst = 0;
    setcol(3'b010);
    issue(4'd5, 8'd3);
    drain();
    setcol(3'b001);
    issue(4'd5, 8'd3);
    drain();
    setcol(3'b100);
    issue(4'd11, 8'd0);
    drain();
    issue(4'd13, 8'd7);
    drain();
    setcol(3'b010);
    issue(4'd2, 8'd50);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    q.delete();
    #1;
    reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    #2 rst = 0;
    issue(4'd2, 8'd1);
    drain();
    rand_col = 1;
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12500: clk cycles per emulation tick.
REQ-002 SHALL have parameter GAP_TICKS, default 4: release ticks after each hold before the command completes.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_col  input  3  column drive from the keypad scanner; bit0=col1, bit1=col2, bit2=col3.
REQ-006 SHALL have port key_row  output  4  emulated row response; bit0..bit3 = row1..row4.
REQ-007 SHALL have port cmd_valid  input  1  press command offered.
REQ-008 SHALL have port cmd_ready  output  1  emulator can accept a command.
REQ-009 SHALL have port cmd_key  input  4  key code: 0-9 digits, 10='*', 11='#', 12-15 invalid.
REQ-010 SHALL have port cmd_hold  input  8  press duration in ticks.
REQ-011 SHALL have port busy  output  1  command in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a valid command completes.
REQ-013 SHALL have port err  output  1  one-cycle pulse when an invalid key is accepted.

Function
REQ-014 SHALL map keys: col1 = 1,4,7,* on rows 1-4; col2 = 2,5,8,0 on rows 1-4; col3 = 3,6,9,# on rows 1-4.
REQ-015 SHALL drive key_row combinationally: the latched key's row bit = pressed AND key_col bit of the latched key's column; all other bits 0; key_col=000 gives 0000; extra driven columns are ignored.
REQ-016 SHALL implement states IDLE, BOUNCE (only when compiled in), HOLD, GAP.
REQ-017 SHALL assert cmd_ready only in IDLE; busy SHALL be the complement of cmd_ready.
REQ-018 SHALL accept a command on a clk edge where cmd_valid and cmd_ready are both 1, latching cmd_key and cmd_hold.
- cmd_key and cmd_hold changes after acceptance are ignored.
REQ-019 SHALL clear the tick prescaler on acceptance; a tick occurs every TICK_DIV clk cycles thereafter.
REQ-020 SHALL treat cmd_hold=0 as 1.
REQ-021 SHALL keep pressed=1 in HOLD for exactly max(cmd_hold,1) ticks.
REQ-022 SHALL keep pressed=0 in GAP for exactly GAP_TICKS ticks, then pulse done and enter IDLE in the same cycle.
REQ-023 SHALL respond to an invalid key as follows:
- pulse err in the cycle after acceptance.
- never assert pressed.
- return to IDLE in that same cycle.
- not pulse done.
REQ-024 SHALL never assert done and err in the same cycle.
REQ-025 SHALL allow a new command to be accepted in the cycle after done or err.

Reset
REQ-026 SHALL, on rst, immediately and asynchronously:
- force state=IDLE and pressed=0.
- clear the prescaler.
- drive key_row=0000, cmd_ready=1, busy=0, done=0, err=0.
REQ-027 SHALL discard any in-progress command when rst asserts, with no done pulse.

Configuration
REQ-028 SHALL support macro KEYEMU_BOUNCE_EN.
- When defined, a valid command first enters BOUNCE for 4 ticks, with pressed = 1,0,1,0 on ticks 0..3, then enters HOLD.
- When undefined, BOUNCE logic SHALL be absent and acceptance goes directly to HOLD.

Verification
REQ-029 SHALL cover reset: assert rst -> key_row=0000, cmd_ready=1, busy=0, done=0, err=0.
REQ-030 SHALL cover a basic press:
- Setup: TICK_DIV=4, GAP_TICKS=2, cmd_key=5, cmd_hold=3, key_col=010.
- Response: key_row=0010 for 12 cycles after acceptance, then 0000; done pulses 20 cycles after acceptance.
- With key_col=001 in the same window, key_row=0000 throughout.
REQ-031 SHALL cover the '#' key and zero hold: cmd_key=11, cmd_hold=0, key_col=100 -> key_row=1000 for exactly 1 tick.
REQ-032 SHALL cover an invalid key: cmd_key=13 -> err pulses 1 cycle, key_row stays 0000, done stays 0, cmd_ready=1 on the next cycle.
REQ-033 SHALL cover reset mid-HOLD: key 2 held, key_col=010, rst asserted -> key_row=0000 in the same cycle, no done pulse; a later command is accepted normally.
REQ-034 SHALL cover bounce: with KEYEMU_BOUNCE_EN, TICK_DIV=4, cmd_key=1, cmd_hold=2, key_col=001 -> key_row bit0 pattern per tick is 1,0,1,0,1,1,0,0, then done pulses.
